// File: rtl/dense_layer_batched.sv
// Batched fully-connected layer y = act(W*x + b) on signed fixed-point words.
// BATCH lanes MAC one input element per cycle; the result register only updates on commit.
module dense_layer_batched #(
  parameter int BITSIZE   = 16,
  parameter int FRAC_BITS = 8,
  parameter int IN_SIZE   = 10,
  parameter int OUT_SIZE  = 92,
  parameter int BATCH     = 32,
  parameter int RELU      = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [BITSIZE*IN_SIZE-1:0]          x,
  input  logic [BITSIZE*OUT_SIZE*IN_SIZE-1:0] w,
  input  logic [BITSIZE*OUT_SIZE-1:0]         b,
  output logic [BITSIZE*OUT_SIZE-1:0]         y,
  output logic                                busy,
  output logic                                done,
  output logic                                valid
);

  localparam int BC  = (OUT_SIZE + BATCH - 1) / BATCH;
  localparam int IW  = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int BW  = (BC > 1) ? $clog2(BC) : 1;
  localparam int OAW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int WAW = $clog2(BITSIZE * OUT_SIZE * IN_SIZE);
  localparam int BAW = $clog2(BITSIZE * OUT_SIZE);
  localparam int WW  = 2 * BITSIZE + 1;

  localparam logic signed [WW-1:0] SAT_MAX = {{(WW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN = {{(WW-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};

  typedef logic signed [BITSIZE-1:0] word_t;
  typedef enum logic [1:0] {IDLE, RUN, COMMIT} state_e;

  function automatic word_t sat(input logic signed [WW-1:0] v);
    if (v > SAT_MAX)      sat = {1'b0, {(BITSIZE-1){1'b1}}};
    else if (v < SAT_MIN) sat = {1'b1, {(BITSIZE-1){1'b0}}};
    else                  sat = v[BITSIZE-1:0];
  endfunction

  state_e                      state_q;
  logic [IW-1:0]               i_q;
  logic [BW-1:0]               batch_q;
  word_t                       x_q   [IN_SIZE];
  word_t                       acc_q [OUT_SIZE];
  logic [BITSIZE*OUT_SIZE-1:0] y_q;
  logic                        busy_q, done_q, valid_q;

  logic [31:0]    lane_o   [BATCH];
  logic           lane_ok  [BATCH];
  logic [OAW-1:0] lane_idx [BATCH];
  word_t          lane_sum [BATCH];

  // Lanes past OUT_SIZE in a ragged final batch are steered to output 0 and never written.
  for (genvar l = 0; l < BATCH; l++) begin : g_lane
    logic signed [2*BITSIZE-1:0] prod;
    word_t xv, wv, bv, base, p_sat;

    assign lane_o[l]   = 32'(batch_q) * 32'(BATCH) + 32'(l);
    assign lane_ok[l]  = lane_o[l] < 32'(OUT_SIZE);
    assign lane_idx[l] = lane_ok[l] ? OAW'(lane_o[l]) : '0;

    assign xv    = x_q[i_q];
    assign wv    = w[WAW'((32'(lane_idx[l]) * IN_SIZE + 32'(i_q)) * BITSIZE) +: BITSIZE];
    assign bv    = b[BAW'(32'(lane_idx[l]) * BITSIZE) +: BITSIZE];
    assign prod  = (2*BITSIZE)'(xv) * (2*BITSIZE)'(wv);
    assign p_sat = sat(WW'(prod >>> FRAC_BITS));
    assign base  = (i_q == '0) ? bv : acc_q[lane_idx[l]];
    assign lane_sum[l] = sat(WW'(base) + WW'(p_sat));
  end

  // NOTE: the accumulator array is reset with the rest of the state so an aborted run leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      batch_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      y_q     <= '0;
      for (int o = 0; o < OUT_SIZE; o++) acc_q[o] <= '0;
      for (int j = 0; j < IN_SIZE; j++) x_q[j] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            for (int j = 0; j < IN_SIZE; j++) x_q[j] <= x[j*BITSIZE +: BITSIZE];
            i_q     <= '0;
            batch_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          for (int l = 0; l < BATCH; l++) begin
            if (lane_ok[l]) acc_q[lane_idx[l]] <= lane_sum[l];
          end
          if (i_q == IW'(IN_SIZE - 1)) begin
            i_q <= '0;
            if (batch_q == BW'(BC - 1)) state_q <= COMMIT;
            else                        batch_q <= batch_q + BW'(1);
          end else begin
            i_q <= i_q + IW'(1);
          end
        end
        COMMIT: begin
          for (int o = 0; o < OUT_SIZE; o++) begin
            y_q[o*BITSIZE +: BITSIZE] <= (RELU != 0 && acc_q[o][BITSIZE-1]) ? '0 : acc_q[o];
          end
          done_q  <= 1'b1;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign y     = y_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_dense_layer_batched.sv
// Directed bench: default layer (identity and ReLU variants) plus a small ragged-batch layer.
module tb_dense_layer_batched;

  localparam int B   = 16;
  localparam int IN  = 10;
  localparam int OUT = 92;

  localparam int RIN  = 3;
  localparam int ROUT = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                start0, start1, startr;
  logic [B*IN-1:0]     x;
  logic [B*OUT*IN-1:0] w;
  logic [B*OUT-1:0]    b;
  logic [B*OUT-1:0]    y0, y1;
  logic                busy0, done0, valid0, busy1, done1, valid1;

  logic [B*RIN-1:0]      xr;
  logic [B*ROUT*RIN-1:0] wr;
  logic [B*ROUT-1:0]     br, yr;
  logic                  busyr, doner, validr;

  dense_layer_batched dut0 (
    .clk(clk), .reset(reset), .start(start0), .x(x), .w(w), .b(b),
    .y(y0), .busy(busy0), .done(done0), .valid(valid0)
  );

  dense_layer_batched #(.RELU(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .x(x), .w(w), .b(b),
    .y(y1), .busy(busy1), .done(done1), .valid(valid1)
  );

  dense_layer_batched #(.IN_SIZE(RIN), .OUT_SIZE(ROUT), .BATCH(4)) dutr (
    .clk(clk), .reset(reset), .start(startr), .x(xr), .w(wr), .b(br),
    .y(yr), .busy(busyr), .done(doner), .valid(validr)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] xv;
    logic [15:0] wv;
    logic [15:0] bv;
    int          sel;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the first word that differs from e, or word 0 if all match.
  function automatic logic [15:0] pick(input logic [B*OUT-1:0] yv, input logic [15:0] e);
    pick = yv[15:0];
    for (int o = OUT - 1; o >= 0; o--) begin
      if (yv[o*B +: B] !== e) pick = yv[o*B +: B];
    end
  endfunction

  task automatic fill(input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] bv);
    for (int j = 0; j < IN; j++) x[j*B +: B] = xv;
    for (int k = 0; k < OUT*IN; k++) w[k*B +: B] = wv;
    for (int o = 0; o < OUT; o++) b[o*B +: B] = bv;
  endtask

  task automatic run_main(input int sel, output int cyc);
    bit busy_ok;
    @(negedge clk);
    if (sel == 0) start0 = 1'b1;
    else          start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    busy_ok = (sel == 0) ? busy0 : busy1;
    cyc = 0;
    while (cyc < 60) begin
      tick();
      cyc++;
      if ((sel == 0) ? done0 : done1) break;
      if (!((sel == 0) ? busy0 : busy1)) busy_ok = 1'b0;
    end
    check("busy_during_run", 32'(busy_ok), 1);
    check("busy_at_done", 32'((sel == 0) ? busy0 : busy1), 0);
    check("latency", cyc, 31);
  endtask

  initial begin
    int cyc, dones, first;
    bit hold_ok;

    vecs[0] = '{16'h0100, 16'h0080, 16'h0000, 0, 16'h0500};
    vecs[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 16'h7FFF};
    vecs[2] = '{16'h7FFF, 16'h8000, 16'h8000, 0, 16'h8000};
    vecs[3] = '{16'h0100, 16'h0000, 16'hFF00, 0, 16'hFF00};
    vecs[4] = '{16'h0100, 16'h0000, 16'hFF00, 1, 16'h0000};
    vecs[5] = '{16'hFF00, 16'h0100, 16'h0200, 0, 16'hF800};
    vecs[6] = '{16'hFF00, 16'h0100, 16'h0200, 1, 16'h0000};
    vecs[7] = '{16'hFFFF, 16'h0080, 16'h0000, 0, 16'hFFF6};
    vecs[8] = '{16'h0100, 16'h0080, 16'h0000, 1, 16'h0500};

    reset = 1'b0;
    start0 = 1'b0; start1 = 1'b0; startr = 1'b0;
    fill(16'h0000, 16'h0000, 16'h0000);
    xr = '0; wr = '0; br = '0;
    repeat (3) tick();

    check("reset_y", 32'(pick(y0, 16'h0000)), 0);
    check("reset_busy", 32'(busy0), 0);
    check("reset_done", 32'(done0), 0);
    check("reset_valid", 32'(valid0), 0);
    check("reset_yr", 32'(yr[15:0]), 0);
    @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 9; v++) begin
      fill(vecs[v].xv, vecs[v].wv, vecs[v].bv);
      run_main(vecs[v].sel, cyc);
      check($sformatf("vec%0d_y", v),
            32'(pick((vecs[v].sel == 0) ? y0 : y1, vecs[v].exp)), 32'(vecs[v].exp));
      tick();
      check($sformatf("vec%0d_done_pulse", v), 32'((vecs[v].sel == 0) ? done0 : done1), 0);
      check($sformatf("vec%0d_valid", v), 32'((vecs[v].sel == 0) ? valid0 : valid1), 1);
    end

    // Hold previous result while running; stray starts during RUN must be ignored.
    fill(16'h0100, 16'h0080, 16'h0000);
    run_main(0, cyc);
    fill(16'h0100, 16'h0040, 16'h0080);
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    dones = 0; first = 0; hold_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      start0 = (n == 10 || n == 20);
      @(posedge clk);
      #1;
      start0 = 1'b0;
      if (done0) begin
        dones++;
        if (first == 0) first = n;
      end
      if (n < 31 && pick(y0, 16'h0500) !== 16'h0500) hold_ok = 1'b0;
    end
    check("hold_prev_y", 32'(hold_ok), 1);
    check("hold_done_edge", first, 31);
    check("hold_done_count", dones, 1);
    check("hold_new_y", 32'(pick(y0, 16'h0300)), 32'h0300);

    // Asynchronous reset between E15 and E16.
    fill(16'h0100, 16'h0080, 16'h0000);
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (15) tick();
    #2;
    reset = 1'b0;
    #1;
    check("abort_y", 32'(pick(y0, 16'h0000)), 0);
    check("abort_busy", 32'(busy0), 0);
    check("abort_done", 32'(done0), 0);
    check("abort_valid", 32'(valid0), 0);
    @(negedge clk);
    reset = 1'b1;
    run_main(0, cyc);
    check("after_abort_y", 32'(pick(y0, 16'h0500)), 32'h0500);

    // Ragged layer: 5 outputs over 4 lanes.
    xr = {16'h0300, 16'h0200, 16'h0100};
    for (int k = 0; k < ROUT*RIN; k++) wr[k*B +: B] = 16'h0100;
    for (int o = 0; o < ROUT; o++) br[o*B +: B] = 16'(o * 256);
    @(negedge clk);
    startr = 1'b1;
    @(posedge clk);
    #1;
    startr = 1'b0;
    cyc = 0;
    while (cyc < 30) begin
      tick();
      cyc++;
      if (doner) break;
    end
    check("ragged_latency", cyc, 7);
    for (int o = 0; o < ROUT; o++) begin
      check($sformatf("ragged_y%0d", o), 32'(yr[o*B +: B]), 32'(16'h0600 + 16'(o * 256)));
    end
    check("ragged_valid", 32'(validr), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dense_layer_batched.md
# dense_layer_batched

Parametrised fully-connected layer, y = act(W·x + b), on signed fixed-point data with a start/done handshake. It is the generalised successor to the fixed 92-output encoder stage. Batch count is derived from OUT_SIZE and BATCH, ragged final batches are handled, and arithmetic saturates. ReLU is optional, and the output register holds the last result while the next computation runs. It sits between feature extraction and the classifier in the arrhythmia-detector datapath.

## Interface
- BITSIZE, 16: word width, signed two's complement.
- FRAC_BITS, 8: fractional bits (Q8.8 at defaults).
- IN_SIZE, 10: input vector length (≥1).
- OUT_SIZE, 92: output vector length (≥1).
- BATCH, 32: MAC lanes working in parallel (≥1).
- RELU, 0: 1 = clamp negative outputs to 0; 0 = identity.
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a computation; sampled only in IDLE.
- x  in  BITSIZE*IN_SIZE  input vector; element j at [j*BITSIZE +: BITSIZE]; captured on the accepting edge.
- w  in  BITSIZE*OUT_SIZE*IN_SIZE  weights; W[o][j] at [(o*IN_SIZE+j)*BITSIZE +: BITSIZE]; must remain stable while busy.
- b  in  BITSIZE*OUT_SIZE  bias; b[o] at [o*BITSIZE +: BITSIZE]; must remain stable while busy.
- y  out  BITSIZE*OUT_SIZE  result register; y[o] at [o*BITSIZE +: BITSIZE].
- busy  out  1  high from the accepting edge until the commit edge.
- done  out  1  one-cycle pulse on commit.
- valid  out  1  sticky; y holds a completed result.

## Operation
- BATCH_COUNT = ceil(OUT_SIZE/BATCH); K = IN_SIZE*BATCH_COUNT.
- FSM states: IDLE, RUN, COMMIT.
  - IDLE→RUN when start=1. On that edge, x is registered, i=0, batch_idx=0, busy=1.
  - RUN: on each edge, lane l (output o = batch_idx*BATCH+l) performs a MAC with element i.
    - Index i advances 0..IN_SIZE-1, then wraps to 0 and batch_idx increments.
    - After the MAC with i=IN_SIZE-1 and batch_idx=BATCH_COUNT-1, the FSM moves to COMMIT.
  - COMMIT→IDLE: y[o] ← act(acc[o]) for all o; done=1 for that cycle; valid=1; busy=0.
- MAC rules:
  - Product p = (x[i]*W[o][i]) as a full 2·BITSIZE-bit signed value, arithmetic right-shifted by FRAC_BITS, then saturated to BITSIZE.
  - For i=0: acc[o] ← sat(b[o]+p). For i>0: acc[o] ← sat(acc[o]+p).
  - Saturation range is [−2^(BITSIZE−1), 2^(BITSIZE−1)−1].
- Ragged batch: lanes with o ≥ OUT_SIZE do no writes and no out-of-range indexing.
- start while busy (RUN or COMMIT) is ignored and never queued.
- y changes only at COMMIT, so the previous result stays visible during RUN.
- Reset (asynchronous, reset=0):
  - FSM goes to IDLE; i, batch_idx and acc are cleared.
  - busy=0, done=0, valid=0, y=0.
  - Reset mid-operation aborts the computation; no done is produced.

## Timing
- Reset values: y=0, busy=0, done=0, valid=0.
- Let E0 be the edge at which start is accepted.
  - RUN occupies E1..EK; state is COMMIT after EK.
  - Commit edge is EK+1: y is updated and done=1, valid=1, busy=0 after it.
  - done returns to 0 after EK+2.
  - The earliest next acceptance is EK+2 (start sampled in IDLE).
- Defaults: BATCH_COUNT=3, K=30; done is high in the cycle after E31.
- Throughput: one result every K+2 cycles with start held high.

## Test plan
- Defaults; x all 0x0100, W all 0x0080, b all 0 → all 92 y = 0x0500; done pulses exactly once, after E31; busy high E0..E31.
- Saturation: x=0x7FFF, W=0x7FFF, b=0x7FFF → every y = 0x7FFF. Then W=0x8000 (x=0x7FFF), b=0x8000 → every y = 0x8000.
- Activation: W=0, b=0xFF00. RELU=0 → y = 0xFF00; RELU=1 → y = 0x0000.
- Hold and ignore: after a run gives 0x0500, start a run expected to give 0x0300.
  - y stays 0x0500 through E31 and becomes 0x0300 at commit.
  - start pulses at E10 and E20 cause no extra done.
- Reset mid-run: assert reset between E15 and E16.
  - Immediately (asynchronously) y=0, busy=0, done=0, valid=0.
  - A fresh start then completes with the correct result at E31.
- Ragged: OUT_SIZE=5, BATCH=4, IN_SIZE=3 (BATCH_COUNT=2, K=6); x=(0x0100,0x0200,0x0300), W[o][j]=0x0100, b[o]=o·0x0100.
  - y[o] = 0x0600 + o·0x0100.
  - done after E7; no out-of-range access (checked by assertion).
